// File: rtl/vend_pkg.sv
// Shared definitions for the candy vending machine.
// Holds the payout FSM state encoding, the change-command widths, the
// default hopper timing, and the coin codes used by the vending controller.
package vend_pkg;

  // Change command: count of 1-unit coins plus a single 5-unit coin flag.
  localparam int BEG_W = 3;

  // Default hopper timing, in clk cycles.
  localparam int PULSE_CYCLES_DEF = 4;
  localparam int ACK_TIMEOUT_DEF  = 255;

  // Coin values and the codes the vending controller reports for inserted coins.
  localparam int BEG_VALUE  = 1;
  localparam int OBEG_VALUE = 5;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_BEG  = 2'd1,
    COIN_OBEG = 2'd2
  } coin_t;

  // Change-payout FSM states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OBEG_EJECT = 3'd1,
    OBEG_WAIT  = 3'd2,
    BEG_EJECT  = 3'd3,
    BEG_WAIT   = 3'd4,
    DONE       = 3'd5,
    FAULT      = 3'd6
  } payout_state_t;

  // A command is a request whenever it asks for at least one coin.
  function automatic logic change_req(input logic [BEG_W-1:0] beg, input logic obeg);
    return (beg != '0) | obeg;
  endfunction

endpackage

// File: rtl/change_payout_sync_edge.sv
// sync_edge: brings an asynchronous level into the clk domain through two
// flops and flags its rising edge using a third history flop.
// Ports:
//   clk, reset (async, active-high)
//   raw  - asynchronous level input
//   rise - one-cycle pulse, high while the synchronized level has just risen
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      // stage 0/1: metastability filter; stage 2: previous synchronized level
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~hist_p2;

endmodule

// File: rtl/change_payout.sv
// change_payout: turns a change command (beg coin count + obeg flag) into
// individual eject pulses for the two coin hoppers. The obeg coin is always
// paid first. Each drop must be confirmed by the hopper sensor; a missing
// confirmation parks the FSM in FAULT until reset.
// Ports:
//   clk, reset (async, active-high)
//   change_beg[2:0], change_obeg   - change command from the vending controller
//   beg_sensed, obeg_sensed        - raw asynchronous hopper drop sensors
//   beg_eject, obeg_eject          - hopper eject pulses
//   busy, done, fault, overrun     - status (fault/overrun sticky)
//   beg_left[2:0], obeg_left       - coins still to pay
module change_payout
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BEG_W-1:0] change_beg,
  input  logic             change_obeg,
  input  logic             beg_sensed,
  input  logic             obeg_sensed,
  output logic             beg_eject,
  output logic             obeg_eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             overrun,
  output logic [BEG_W-1:0] beg_left,
  output logic             obeg_left
);

  localparam int PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int WCNT_W = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ACK_TIMEOUT - 1);

  payout_state_t     state, state_nxt;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [BEG_W-1:0]  beg_left_nxt;
  logic              obeg_left_nxt;
  logic              req, req_d, req_rise;
  logic              beg_rise, obeg_rise;

  sync_edge u_beg_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (beg_sensed),
    .rise  (beg_rise)
  );

  sync_edge u_obeg_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (obeg_sensed),
    .rise  (obeg_rise)
  );

  assign req      = change_req(change_beg, change_obeg);
  assign req_rise = req & ~req_d;

  always_comb begin
    state_nxt     = state;
    pcnt_nxt      = pcnt;
    wcnt_nxt      = wcnt;
    beg_left_nxt  = beg_left;
    obeg_left_nxt = obeg_left;
    case (state)
      IDLE: begin
        // Only a rising request loads, so a held command never repeats.
        if (req_rise) begin
          beg_left_nxt  = change_beg;
          obeg_left_nxt = change_obeg;
          pcnt_nxt      = '0;
          state_nxt     = change_obeg ? OBEG_EJECT : BEG_EJECT;
        end
      end
      OBEG_EJECT, BEG_EJECT: begin
        if (pcnt == PCNT_LAST) begin
          pcnt_nxt  = '0;
          wcnt_nxt  = '0;
          state_nxt = (state == OBEG_EJECT) ? OBEG_WAIT : BEG_WAIT;
        end else begin
          pcnt_nxt = pcnt + PCNT_W'(1);
        end
      end
      OBEG_WAIT: begin
        // A drop confirmation takes priority over a timeout on the same edge.
        if (obeg_rise) begin
          obeg_left_nxt = 1'b0;
          pcnt_nxt      = '0;
          state_nxt     = (beg_left != '0) ? BEG_EJECT : DONE;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt = FAULT;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      BEG_WAIT: begin
        if (beg_rise) begin
          beg_left_nxt = beg_left - BEG_W'(1);
          pcnt_nxt     = '0;
          state_nxt    = (beg_left_nxt != '0) ? BEG_EJECT : DONE;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt = FAULT;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pcnt      <= '0;
      wcnt      <= '0;
      beg_left  <= '0;
      obeg_left <= 1'b0;
      req_d     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      wcnt      <= wcnt_nxt;
      beg_left  <= beg_left_nxt;
      obeg_left <= obeg_left_nxt;
      req_d     <= req;
      if (req_rise && (state != IDLE)) overrun <= 1'b1;
    end
  end

  // Outputs decode the state register only, so the async reset drops the
  // ejects immediately and no output follows an input combinationally.
  assign obeg_eject = (state == OBEG_EJECT);
  assign beg_eject  = (state == BEG_EJECT);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign fault      = (state == FAULT);

endmodule

// File: tb/tb_change_payout.sv
module tb_change_payout;

  localparam int P = 4;
  localparam int T = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] change_beg;
  logic       change_obeg;
  logic       beg_sensed;
  logic       obeg_sensed;
  logic       beg_eject;
  logic       obeg_eject;
  logic       busy;
  logic       done;
  logic       fault;
  logic       overrun;
  logic [2:0] beg_left;
  logic       obeg_left;

  int n_chk  = 0;
  int n_pass = 0;

  change_payout dut (
    .clk         (clk),
    .reset       (reset),
    .change_beg  (change_beg),
    .change_obeg (change_obeg),
    .beg_sensed  (beg_sensed),
    .obeg_sensed (obeg_sensed),
    .beg_eject   (beg_eject),
    .obeg_eject  (obeg_eject),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .overrun     (overrun),
    .beg_left    (beg_left),
    .obeg_left   (obeg_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One coin: measure the eject pulse, optionally glitch the command to
  // provoke an overrun, then confirm the drop and check the 2-edge latency.
  task automatic coin(input bit ob, input int exp_left, input bit glitch, input string tag);
    int n;
    int t;
    bit overlap;
    t = 0;
    while (((ob ? obeg_eject : beg_eject) !== 1'b1) && t < 20) begin
      tick();
      t++;
    end
    chk({tag, "_eject_on"}, ob ? obeg_eject : beg_eject, 1);
    n = 0;
    overlap = 1'b0;
    while (((ob ? obeg_eject : beg_eject) === 1'b1) && n < 50) begin
      if ((ob ? beg_eject : obeg_eject) !== 1'b0) overlap = 1'b1;
      n++;
      tick();
    end
    chk({tag, "_width"}, n, P);
    chk({tag, "_overlap"}, overlap, 0);
    if (glitch) begin
      change_beg  = 3'd0;
      change_obeg = 1'b0;
      tick();
      change_beg = 3'd7;
      tick();
    end else begin
      repeat (2) tick();
    end
    if (ob) obeg_sensed = 1'b1;
    else    beg_sensed  = 1'b1;
    repeat (2) tick();
    chk({tag, "_left_hold"}, ob ? obeg_left : beg_left, exp_left + 1);
    tick();
    chk({tag, "_left_dec"}, ob ? obeg_left : beg_left, exp_left);
    obeg_sensed = 1'b0;
    beg_sensed  = 1'b0;
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    change_beg  = 3'd0;
    change_obeg = 1'b0;
    beg_sensed  = 1'b0;
    obeg_sensed = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ejects", {beg_eject, obeg_eject}, 0);
    chk("rst_flags", {done, fault, overrun}, 0);
    chk("rst_left", {beg_left, obeg_left}, 0);
    reset = 1'b0;
    tick();

    // Three beg coins, command held across done.
    change_beg = 3'd3;
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_eject", beg_eject, 1);
    chk("t1_left", beg_left, 3);
    coin(1'b0, 2, 1'b0, "t1_c1");
    coin(1'b0, 1, 1'b0, "t1_c2");
    coin(1'b0, 0, 1'b0, "t1_c3");
    chk("t1_done", done, 1);
    chk("t1_busy_at_done", busy, 1);
    tick();
    chk("t1_done_fall", done, 0);
    chk("t1_busy_fall", busy, 0);
    repeat (3) tick();
    chk("t1_no_reload", busy, 0);
    chk("t1_no_overrun", overrun, 0);
    change_beg = 3'd0;
    tick();
    change_beg = 3'd1;
    tick();
    chk("t4_reload_busy", busy, 1);
    chk("t4_reload_left", beg_left, 1);
    coin(1'b0, 0, 1'b0, "t4_c1");
    chk("t4_done", done, 1);
    tick();
    chk("t4_idle", busy, 0);
    change_beg = 3'd0;
    tick();

    // obeg first, then two beg coins; overrun provoked mid-payout.
    change_beg  = 3'd2;
    change_obeg = 1'b1;
    tick();
    chk("t2_obeg_eject", obeg_eject, 1);
    chk("t2_beg_idle", beg_eject, 0);
    chk("t2_left", {beg_left, obeg_left}, {3'd2, 1'b1});
    coin(1'b1, 0, 1'b0, "t2_ob");
    chk("t2_obeg_clear", obeg_left, 0);
    chk("t2_beg_start", beg_eject, 1);
    coin(1'b0, 1, 1'b1, "t2_c1");
    chk("t2_overrun", overrun, 1);
    coin(1'b0, 0, 1'b0, "t2_c2");
    chk("t2_done", done, 1);
    repeat (3) tick();
    chk("t2_idle", busy, 0);
    chk("t2_overrun_sticky", overrun, 1);
    change_beg  = 3'd0;
    change_obeg = 1'b0;
    tick();

    // One beg coin, sensor pulse only during eject, then timeout.
    change_beg = 3'd1;
    tick();
    n = 0;
    beg_sensed = 1'b1;
    tick();
    n++;
    beg_sensed = 1'b0;
    while (fault !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("t3_fault_time", n, P + T);
    chk("t3_fault", fault, 1);
    chk("t3_left", beg_left, 1);
    chk("t3_ejects", {beg_eject, obeg_eject}, 0);
    change_beg = 3'd0;
    repeat (10) tick();
    chk("t3_busy_held", busy, 1);
    chk("t3_fault_held", fault, 1);

    // Reset clears the fault; then reset mid-pulse with command held.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_clear", {busy, fault, overrun}, 0);
    change_beg = 3'd2;
    tick();
    tick();
    chk("t6_pre_eject", beg_eject, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_eject", beg_eject, 0);
    chk("t6_async_flags", {busy, done, fault, overrun}, 0);
    chk("t6_async_left", {beg_left, obeg_left}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("t6_reload_busy", busy, 1);
    chk("t6_reload_left", beg_left, 2);
    coin(1'b0, 1, 1'b0, "t6_c1");
    coin(1'b0, 0, 1'b0, "t6_c2");
    chk("t6_done", done, 1);
    tick();
    chk("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
